// File: rtl/down_counter_if.sv
// Control/status bundle for the loadable down-counter.
// The master drives commands and observes status; the slave is the counter.
interface down_counter_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             stop;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             paused;
    logic             tc;

    modport master (
        output load, load_val, start, stop, auto_reload,
        input  count, busy, paused, tc
    );

    modport slave (
        input  load, load_val, start, stop, auto_reload,
        output count, busy, paused, tc
    );
endinterface

// File: rtl/down_counter.sv
// Loadable down-counter/timer with start, stop (pause) and optional auto-reload.
// Counts a loaded value down to zero, pulsing tc for one cycle when zero is
// first reached. All outputs are registered.
module down_counter #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    down_counter_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q,     tc_d;
    logic             busy_q,   busy_d;
    logic             paused_q, paused_d;

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= ZERO;
            reload_q <= ZERO;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            paused_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            busy_q   <= busy_d;
            paused_q <= paused_d;
        end
    end

    // Next state and datapath: load beats stop beats start beats counting.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (bus.load) begin
            // Abandons any count in progress without a tc pulse.
            count_d  = bus.load_val;
            reload_d = bus.load_val;
            state_d  = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    // A start with nothing to count is silently dropped.
                    if (bus.start && (count_q != ZERO))
                        state_d = RUN;
                end
                RUN: begin
                    if (bus.stop) begin
                        state_d = PAUSE;
                    end else if (count_q > ONE) begin
                        count_d = count_q - ONE;
                    end else if (count_q == ONE) begin
                        // Stay in RUN one cycle displaying zero with tc.
                        count_d = ZERO;
                        tc_d    = 1'b1;
                    end else if (bus.auto_reload) begin
                        // A zero reload value just keeps RUN spinning at zero.
                        count_d = reload_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
                PAUSE: begin
                    // start together with stop keeps the counter paused.
                    if (bus.start && !bus.stop)
                        state_d = RUN;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d   = (state_d == RUN);
        paused_d = (state_d == PAUSE);
    end

    assign bus.count  = count_q;
    assign bus.busy   = busy_q;
    assign bus.paused = paused_q;
    assign bus.tc     = tc_q;

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: directed scenarios plus a randomized
// run compared against a behavioural model of the counter.
module tb_down_counter;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    down_counter_if #(.WIDTH(4)) bus ();

    down_counter #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.load        = 1'b0;
        bus.load_val    = 4'd0;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.auto_reload = 1'b0;
    endtask

    task automatic do_load(input logic [3:0] v);
        bus.load     = 1'b1;
        bus.load_val = v;
        tick();
        bus.load     = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        #12;
        checks++;
        if ({bus.count, bus.busy, bus.paused, bus.tc} !== 7'b0000_000) begin
            errors++;
            $display("FAIL reset_state: got cnt=%0d busy=%b paused=%b tc=%b, want all 0",
                     bus.count, bus.busy, bus.paused, bus.tc);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_one_shot();
        logic [6:0] exp [6];
        // {count, busy, paused, tc} after each edge following the start edge
        exp = '{ {4'd2,3'b100}, {4'd1,3'b100}, {4'd0,3'b101},
                 {4'd0,3'b000}, {4'd0,3'b000}, {4'd0,3'b000} };
        bus.auto_reload = 1'b0;
        do_load(4'd3);
        checks++;
        if ({bus.count, bus.busy, bus.tc} !== {4'd3, 2'b00}) begin
            errors++;
            $display("FAIL oneshot_load: got cnt=%0d busy=%b tc=%b, want 3 0 0",
                     bus.count, bus.busy, bus.tc);
        end
        do_start();
        checks++;
        if ({bus.count, bus.busy, bus.paused, bus.tc} !== {4'd3, 3'b100}) begin
            errors++;
            $display("FAIL oneshot_start: got cnt=%0d busy=%b, want 3 1", bus.count, bus.busy);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({bus.count, bus.busy, bus.paused, bus.tc} !== exp[i]) begin
                errors++;
                $display("FAIL oneshot_cyc%0d: got %b want %b", i,
                         {bus.count, bus.busy, bus.paused, bus.tc}, exp[i]);
            end
        end
    endtask

    task automatic test_periodic();
        logic [3:0] exp_cnt [9];
        int tcs;
        exp_cnt = '{4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd2};
        tcs = 0;
        bus.auto_reload = 1'b1;
        do_load(4'd2);
        do_start();
        for (int i = 0; i < 9; i++) begin
            tick();
            if (bus.tc) tcs++;
            checks++;
            if (bus.count !== exp_cnt[i] || bus.busy !== 1'b1 ||
                bus.tc !== (exp_cnt[i] == 4'd0)) begin
                errors++;
                $display("FAIL periodic_cyc%0d: got cnt=%0d busy=%b tc=%b want cnt=%0d busy=1 tc=%b",
                         i, bus.count, bus.busy, bus.tc, exp_cnt[i], exp_cnt[i] == 4'd0);
            end
        end
        checks++;
        if (tcs != 3) begin
            errors++;
            $display("FAIL periodic_tc_count: got %0d want 3", tcs);
        end
        bus.auto_reload = 1'b0;
        do_load(4'd0);
    endtask

    task automatic test_pause_resume();
        int tcs;
        tcs = 0;
        do_load(4'd6);
        do_start();
        tick();
        tick();
        checks++;
        if (bus.count !== 4'd4 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL pause_pre: got cnt=%0d busy=%b want 4 1", bus.count, bus.busy);
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            checks++;
            if ({bus.count, bus.busy, bus.paused, bus.tc} !== {4'd4, 3'b010}) begin
                errors++;
                $display("FAIL pause_hold%0d: got cnt=%0d busy=%b paused=%b want 4 0 1",
                         i, bus.count, bus.busy, bus.paused);
            end
        end
        do_start();
        checks++;
        if ({bus.count, bus.busy, bus.paused} !== {4'd4, 2'b10}) begin
            errors++;
            $display("FAIL resume: got cnt=%0d busy=%b paused=%b want 4 1 0",
                     bus.count, bus.busy, bus.paused);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.tc) tcs++;
            checks++;
            if (bus.count !== 4'(3 - i)) begin
                errors++;
                $display("FAIL resume_cnt%0d: got %0d want %0d", i, bus.count, 3 - i);
            end
        end
        tick();
        if (bus.tc) tcs++;
        checks++;
        if (tcs != 1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL resume_end: got tcs=%0d busy=%b want 1 0", tcs, bus.busy);
        end
    endtask

    task automatic test_priority();
        do_load(4'd4);
        do_start();
        bus.stop = 1'b1;
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        checks++;
        if ({bus.count, bus.busy, bus.paused} !== {4'd4, 2'b01}) begin
            errors++;
            $display("FAIL prio_start_stop: got cnt=%0d busy=%b paused=%b want 4 0 1",
                     bus.count, bus.busy, bus.paused);
        end
        do_load(4'd3);
        do_start();
        tick();
        checks++;
        if (bus.count !== 4'd2) begin
            errors++;
            $display("FAIL prio_pre: got cnt=%0d want 2", bus.count);
        end
        bus.load     = 1'b1;
        bus.load_val = 4'd9;
        bus.start    = 1'b1;
        tick();
        bus.load  = 1'b0;
        bus.start = 1'b0;
        checks++;
        if ({bus.count, bus.busy, bus.paused, bus.tc} !== {4'd9, 3'b000}) begin
            errors++;
            $display("FAIL prio_load: got cnt=%0d busy=%b paused=%b tc=%b want 9 0 0 0",
                     bus.count, bus.busy, bus.paused, bus.tc);
        end
    endtask

    task automatic test_zero_and_max();
        int tcs;
        int runs;
        tcs  = 0;
        runs = 0;
        do_load(4'd0);
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bus.count, bus.busy, bus.tc} !== {4'd0, 2'b00}) begin
                errors++;
                $display("FAIL zero_start%0d: got cnt=%0d busy=%b tc=%b want 0 0 0",
                         i, bus.count, bus.busy, bus.tc);
            end
        end
        bus.start = 1'b0;
        do_load(4'd15);
        do_start();
        runs = 1;
        for (int i = 0; i < 17; i++) begin
            tick();
            if (bus.busy) runs++;
            if (bus.tc) tcs++;
        end
        checks++;
        if (runs != 16 || tcs != 1 || bus.busy !== 1'b0 || bus.count !== 4'd0) begin
            errors++;
            $display("FAIL max_load: got runs=%0d tcs=%0d busy=%b cnt=%0d want 16 1 0 0",
                     runs, tcs, bus.busy, bus.count);
        end
    endtask

    task automatic test_reset_mid_run();
        do_load(4'd5);
        do_start();
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.count, bus.busy, bus.paused, bus.tc} !== 7'b0000_000) begin
            errors++;
            $display("FAIL async_reset: got cnt=%0d busy=%b paused=%b tc=%b want all 0",
                     bus.count, bus.busy, bus.paused, bus.tc);
        end
        @(negedge clk);
        reset = 1'b0;
        do_start();
        tick();
        checks++;
        if ({bus.count, bus.busy, bus.tc} !== {4'd0, 2'b00}) begin
            errors++;
            $display("FAIL start_after_reset: got cnt=%0d busy=%b tc=%b want 0 0 0",
                     bus.count, bus.busy, bus.tc);
        end
    endtask

    // Randomized commands against a mode/count model of the timer's rules.
    task automatic test_random();
        logic [3:0] m_cnt;
        logic [3:0] m_rl;
        int         m_mode;   // 0 idle, 1 counting, 2 paused
        logic       m_tc;
        reset = 1'b1;
        #2;
        @(negedge clk);
        reset  = 1'b0;
        m_cnt  = 4'd0;
        m_rl   = 4'd0;
        m_mode = 0;
        for (int i = 0; i < 400; i++) begin
            bus.load        = ($urandom_range(0, 99) < 8);
            bus.load_val    = 4'($urandom_range(0, 15));
            bus.start       = ($urandom_range(0, 99) < 30);
            bus.stop        = ($urandom_range(0, 99) < 8);
            bus.auto_reload = ($urandom_range(0, 99) < 50);
            m_tc = 1'b0;
            if (bus.load) begin
                m_cnt  = bus.load_val;
                m_rl   = bus.load_val;
                m_mode = 0;
            end else if (m_mode == 0) begin
                if (bus.start && m_cnt != 0) m_mode = 1;
            end else if (m_mode == 2) begin
                if (bus.start && !bus.stop) m_mode = 1;
            end else if (bus.stop) begin
                m_mode = 2;
            end else if (m_cnt != 0) begin
                m_cnt = m_cnt - 4'd1;
                m_tc  = (m_cnt == 0);
            end else if (bus.auto_reload) begin
                m_cnt = m_rl;
            end else begin
                m_mode = 0;
            end
            tick();
            checks++;
            if (bus.count !== m_cnt || bus.busy !== (m_mode == 1) ||
                bus.paused !== (m_mode == 2) || bus.tc !== m_tc) begin
                errors++;
                $display("FAIL random_cyc%0d: got cnt=%0d busy=%b paused=%b tc=%b want cnt=%0d busy=%b paused=%b tc=%b",
                         i, bus.count, bus.busy, bus.paused, bus.tc,
                         m_cnt, m_mode == 1, m_mode == 2, m_tc);
            end
        end
        idle_inputs();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_one_shot();
        test_periodic();
        test_pause_resume();
        test_priority();
        test_zero_and_max();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
